alu_share_arbiter: RTL and testbench

Sequencer that shares one 64-bit integer ALU (add, sub, and, xor) between two requesters, e.g. the execute stage and an address/stack-pointer update path. Requests use a valid/ready handshake and are granted round-robin. Each accepted request runs through a three-state FSM, and its result is held on a registered response port until consumed. When compiled in, the block also maintains the ZF/SF/OF condition-code register for the Y86 datapath.

---
 rtl/alu_share_arbiter_pkg.sv | 24 ++
 rtl/alu_share_arbiter_if.sv | 34 +++
 rtl/alu_share_arbiter_alu64_core.sv | 32 +++
 rtl/alu_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the two-requester shared 64-bit ALU sequencer.
package alu_share_arbiter_pkg;

  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic CC_ZF_RST   = 1'b1;
  localparam logic CC_SF_RST   = 1'b0;
  localparam logic CC_OF_RST   = 1'b0;
  localparam logic LAST_RST    = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the result consumer
// and alu_share_arbiter; master is the requester side, slave is the arbiter.
interface alu_share_arbiter_if;
  import alu_share_arbiter_pkg::*;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_op0;
  logic [1:0]        req_op1;
  logic [DATA_W-1:0] req_a0;
  logic [DATA_W-1:0] req_b0;
  logic [DATA_W-1:0] req_a1;
  logic [DATA_W-1:0] req_b1;
  logic [1:0]        req_setcc;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_result;
  logic              resp_of;
  logic              cc_zf;
  logic              cc_sf;
  logic              cc_of;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, req_setcc, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_of, cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, req_setcc, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_of, cc_zf, cc_sf, cc_of
  );

endinterface

// File: rtl/alu_share_arbiter_alu64_core.sv
// Combinational 64-bit ALU (add/sub/and/xor) with signed-overflow output.
module alu64_core
  import alu_share_arbiter_pkg::*;
(
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              of
);

  logic              is_sub;
  logic [DATA_W-1:0] b_eff;

  always_comb begin
    is_sub = (op == ALU_SUB);
    b_eff  = is_sub ? ~b : b;
    result = '0;
    of     = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        // Subtract as a + ~b + 1 so one adder and one overflow rule serve both.
        result = a + b_eff + DATA_W'(is_sub);
        of     = (a[DATA_W-1] == b_eff[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one 64-bit ALU between two requesters with a held response port.
// Macro ALU_SHARE_ARBITER_CC_EN adds the ZF/SF/OF condition-code register.
//
// state   | meaning
// IDLE    | waiting for a request; req_ready shows the granted requester
// EXEC    | ALU evaluates latched operands; result registered at cycle end
// RESP    | resp_valid high, outputs held until resp_ready
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic              last_served;
  logic              grant;
  logic              accept;
  logic [1:0]        ready;

  alu_op_t           op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              id_q;

  logic              resp_valid_q;
  logic              resp_id_q;
  logic [DATA_W-1:0] resp_result_q;
  logic              resp_of_q;

  logic [DATA_W-1:0] alu_result;
  logic              alu_of;

  alu64_core u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .of     (alu_of)
  );

  always_comb begin
    grant = 1'b0;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_served;
      default: grant = 1'b0;
    endcase
  end

  // Ready is gated by rst_n so nothing is offered during the reset cycle.
  always_comb begin
    state_nxt = state;
    ready     = 2'b00;
    case (state)
      ST_IDLE: begin
        ready[grant] = bus.req_valid[grant] & rst_n;
        if (ready[grant]) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept        = |ready;
  assign bus.req_ready = ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last_served   <= LAST_RST;
      op_q          <= ALU_ADD;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_of_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q        <= alu_op_t'(grant ? bus.req_op1 : bus.req_op0);
        a_q         <= grant ? bus.req_a1 : bus.req_a0;
        b_q         <= grant ? bus.req_b1 : bus.req_b0;
        id_q        <= grant;
        last_served <= grant;
      end
      if (state == ST_EXEC) begin
        resp_valid_q  <= 1'b1;
        resp_id_q     <= id_q;
        resp_result_q <= alu_result;
        resp_of_q     <= alu_of;
      end else if ((state == ST_RESP) && bus.resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_of     = resp_of_q;

`ifdef ALU_SHARE_ARBITER_CC_EN
  logic setcc_q;
  logic zf_q;
  logic sf_q;
  logic of_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      setcc_q <= 1'b0;
      zf_q    <= CC_ZF_RST;
      sf_q    <= CC_SF_RST;
      of_q    <= CC_OF_RST;
    end else begin
      if (accept) setcc_q <= grant ? bus.req_setcc[1] : bus.req_setcc[0];
      if ((state == ST_EXEC) && setcc_q) begin
        zf_q <= (alu_result == '0);
        sf_q <= alu_result[DATA_W-1];
        of_q <= alu_of;
      end
    end
  end

  assign bus.cc_zf = zf_q;
  assign bus.cc_sf = sf_q;
  assign bus.cc_of = of_q;
`else
  logic unused_setcc;
  assign unused_setcc = ^bus.req_setcc;
  assign bus.cc_zf    = 1'b0;
  assign bus.cc_sf    = 1'b0;
  assign bus.cc_of    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed scenarios then randomized traffic
// against an arithmetic reference model; follows ALU_SHARE_ARBITER_CC_EN if defined.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        id;
    logic [63:0] result;
    logic        of;
    logic        zf;
    logic        sf;
    logic        cof;
    int          cyc;
  } exp_t;

  localparam logic signed [65:0] MAXS = 66'sd9223372036854775807;
  localparam logic signed [65:0] MINS = -66'sd9223372036854775808;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic        last_m;
  logic        busy;
  logic        m_zf, m_sf, m_of;
  logic [1:0]  p_op [2];
  logic [63:0] p_a [2];
  logic [63:0] p_b [2];
  logic        p_sc [2];
  logic        pend [2];
  int          fill_mode;
  logic        fix_sc;
  int          new_pct, drop_pct, rr_pct;
  bit          chk_interval;
  int          acc_count;
  int          prev_acc;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: wide signed arithmetic decides overflow by range, not by sign bits.
  function automatic logic [64:0] alu_ref(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic signed [65:0] wa, wb, w;
    wa = $signed({{2{a[63]}}, a});
    wb = $signed({{2{b[63]}}, b});
    case (op)
      2'b00: begin w = wa + wb; return {(w > MAXS) || (w < MINS), a + b}; end
      2'b01: begin w = wa - wb; return {(w > MAXS) || (w < MINS), a - b}; end
      2'b10: return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic drive();
    bus.req_valid = {pend[1], pend[0]};
    bus.req_op0   = p_op[0];
    bus.req_op1   = p_op[1];
    bus.req_a0    = p_a[0];
    bus.req_b0    = p_b[0];
    bus.req_a1    = p_a[1];
    bus.req_b1    = p_b[1];
    bus.req_setcc = {p_sc[1], p_sc[0]};
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic sc);
    p_op[i] = op; p_a[i] = a; p_b[i] = b; p_sc[i] = sc; pend[i] = 1'b1;
    drive();
  endtask

  task automatic refresh();
    for (int i = 0; i < 2; i++) begin
      if (pend[i] && ($urandom_range(0, 99) < drop_pct)) begin
        pend[i] = 1'b0;
      end else if (!pend[i]) begin
        if (fill_mode == 1) begin
          p_op[i] = ALU_ADD; p_a[i] = 64'd1; p_b[i] = 64'd1; p_sc[i] = fix_sc; pend[i] = 1'b1;
        end else if ((fill_mode == 2) && ($urandom_range(0, 99) < new_pct)) begin
          p_op[i] = 2'($urandom_range(0, 3));
          p_a[i]  = rand_operand();
          p_b[i]  = rand_operand();
          p_sc[i] = 1'($urandom_range(0, 1));
          pend[i] = 1'b1;
        end
      end
    end
    bus.resp_ready = ($urandom_range(0, 99) < rr_pct);
    drive();
  endtask

  task automatic accept(input int i);
    exp_t e;
    logic [64:0] r;
    r = alu_ref(p_op[i], p_a[i], p_b[i]);
`ifdef ALU_SHARE_ARBITER_CC_EN
    if (p_sc[i]) begin
      m_zf = (r[63:0] == 64'd0);
      m_sf = r[63];
      m_of = r[64];
    end
`endif
    e.id = i[0]; e.result = r[63:0]; e.of = r[64];
    e.zf = m_zf; e.sf = m_sf; e.cof = m_of; e.cyc = cyc;
    sb.push_back(e);
    if (chk_interval && (acc_count > 0)) chk("issue_interval", 64'(cyc - prev_acc), 64'd3);
    prev_acc = cyc;
    acc_count++;
    last_m = i[0];
    busy = 1'b1;
    pend[i] = 1'b0;
  endtask

  task automatic step();
    logic [1:0] exp_rdy;
    bit consumed;
    @(negedge clk);
    exp_rdy = 2'b00;
    if (!busy) begin
      case (bus.req_valid)
        2'b01: exp_rdy = 2'b01;
        2'b10: exp_rdy = 2'b10;
        2'b11: exp_rdy = last_m ? 2'b01 : 2'b10;
        default: exp_rdy = 2'b00;
      endcase
    end
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    consumed = busy && bus.resp_valid && bus.resp_ready;
    for (int i = 0; i < 2; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) accept(i);
    @(posedge clk);
    #1;
    if (consumed) busy = 1'b0;
    refresh();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((busy || (sb.size() != 0) || pend[0] || pend[1]) && (n < max_cycles)) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(n >= max_cycles), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, ALU_ADD, 64'd2, 64'd2, 1'b1);
    set_req(1, ALU_SUB, 64'd2, 64'd2, 1'b1);
    sb.delete();
    busy = 1'b0;
    last_m = 1'b1;
`ifdef ALU_SHARE_ARBITER_CC_EN
    m_zf = 1'b1;
`else
    m_zf = 1'b0;
`endif
    m_sf = 1'b0;
    m_of = 1'b0;
    @(negedge clk);
    chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
    chk("rst_resp_result", bus.resp_result, 64'd0);
    chk("rst_resp_of", 64'(bus.resp_of), 64'd0);
    chk("rst_cc_zf", 64'(bus.cc_zf), 64'(m_zf));
    chk("rst_cc_sf", 64'(bus.cc_sf), 64'd0);
    chk("rst_cc_of", 64'(bus.cc_of), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
  endtask

  // Monitor: pops one expectation per presented response and checks it stays held.
  initial begin : monitor
    exp_t e, h;
    bit held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else if (bus.resp_valid) begin
        if (!held) begin
          if (sb.size() == 0) begin
            chk("spurious_resp", 64'(bus.resp_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("resp_id", 64'(bus.resp_id), 64'(e.id));
            chk("resp_result", bus.resp_result, e.result);
            chk("resp_of", 64'(bus.resp_of), 64'(e.of));
            chk("cc_zf", 64'(bus.cc_zf), 64'(e.zf));
            chk("cc_sf", 64'(bus.cc_sf), 64'(e.sf));
            chk("cc_of", 64'(bus.cc_of), 64'(e.cof));
            chk("latency", 64'(cyc - e.cyc), 64'd2);
            h = e;
            held = 1'b1;
          end
        end else begin
          chk("hold_result", bus.resp_result, h.result);
          chk("hold_id", 64'(bus.resp_id), 64'(h.id));
        end
        if (bus.resp_ready) held = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int n;
    fill_mode = 0; fix_sc = 1'b0; new_pct = 0; drop_pct = 0; rr_pct = 100;
    chk_interval = 1'b0; acc_count = 0; prev_acc = 0;
    last_m = 1'b1; busy = 1'b0; m_zf = 1'b0; m_sf = 1'b0; m_of = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_op[i] = 2'b00; p_a[i] = '0; p_b[i] = '0; p_sc[i] = 1'b0; pend[i] = 1'b0;
    end
    bus.resp_ready = 1'b1;
    drive();
    do_reset();

    set_req(0, ALU_SUB, 64'd5, 64'd7, 1'b1);
    drain(20);

    fill_mode = 1; fix_sc = 1'b1; chk_interval = 1'b1; acc_count = 0;
    refresh();
    repeat (24) step();
    fill_mode = 0; chk_interval = 1'b0;
    drain(20);

    set_req(1, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    drain(20);
    set_req(0, ALU_XOR, 64'h55, 64'h55, 1'b0);
    drain(20);

    fill_mode = 1; fix_sc = 1'b0; rr_pct = 0; acc_count = 0;
    refresh();
    repeat (9) step();
    chk("accepts_while_stalled", 64'(acc_count), 64'd1);
    fill_mode = 0; rr_pct = 100;
    drain(30);

    set_req(0, ALU_SUB, 64'd3, 64'd3, 1'b1);
    acc_count = 0;
    n = 0;
    while ((acc_count == 0) && (n < 10)) begin
      step();
      n++;
    end
    chk("mid_op_accept", 64'(acc_count), 64'd1);
    do_reset();
    repeat (6) step();
    chk("no_resp_after_reset", 64'(sb.size()), 64'd0);

    set_req(0, ALU_SUB, 64'd3, 64'd3, 1'b1);
    drain(20);

    fill_mode = 2; new_pct = 50; drop_pct = 10; rr_pct = 70;
    repeat (1500) step();
    fill_mode = 0; drop_pct = 0; rr_pct = 100;
    drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
